hi_lo_mul_div: RTL and testbench

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers and drives the `ReadDataHi`/`ReadDataLo` inputs of the write-back stage for MFHI/MFLO. It sits beside the execute stage. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from decode/execute and iterates one bit per cycle. It raises `Stall` to hold the pipeline whenever an instruction touches HI/LO while an operation is in flight.

---
 rtl/hi_lo_mul_div_pkg.sv | 29 ++
 rtl/mul_div_iterator.sv | 72 +++++++
 rtl/hi_lo_mul_div.sv | 179 +++++++++++++++++
 tb/tb_hi_lo_mul_div.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hi_lo_mul_div_pkg.sv
// HI/LO multiply-divide unit shared definitions.
// Op codes, FSM states and divide-by-zero result.
package hi_lo_mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  // Quotient reported on divide by zero (sliced to width).
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_iterator.sv
// Bit-serial shift-add multiply / restoring divide.
// Operands are unsigned magnitudes; one bit per cycle.
module mul_div_iterator
  import hi_lo_mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  run,
  input  logic                  isDiv,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  output logic [DATA_WIDTH-1:0] hiRes,
  output logic [DATA_WIDTH-1:0] loRes,
  output logic                  lastIter
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] opnd;
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   mulSum;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  // One-step datapath for both multiply and divide.
  always_comb begin
    addend  = quo[0] ? opnd : {DATA_WIDTH{1'b0}};
    mulSum  = {1'b0, acc} + {1'b0, addend};
    shifted = {acc, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
  end

  // Shadow accumulator, quotient/multiplier and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      quo  <= '0;
      opnd <= '0;
    end else if (load) begin
      cnt  <= CW'(DATA_WIDTH);
      acc  <= '0;
      quo  <= opA;
      opnd <= opB;
    end else if (run) begin
      cnt <= cnt - CW'(1);
      if (isDiv) begin
        if (!diff[DATA_WIDTH]) begin
          acc <= diff[DATA_WIDTH-1:0];
          quo <= {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted[DATA_WIDTH-1:0];
          quo <= {quo[DATA_WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= mulSum[DATA_WIDTH:1];
        quo <= {mulSum[0], quo[DATA_WIDTH-1:1]};
      end
    end
  end

  assign hiRes    = acc;
  assign loRes    = quo;
  assign lastIter = (cnt == CW'(1));

endmodule

// File: rtl/hi_lo_mul_div.sv
// Multi-cycle MULT/DIV unit owning HI and LO.
// FSM, sign handling, HI/LO registers, stall.
module hi_lo_mul_div
  import hi_lo_mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  HiWrite,
  input  logic                  LoWrite,
  input  logic [DATA_WIDTH-1:0] MoveData,
  input  logic                  HiLoRead,
  output logic [DATA_WIDTH-1:0] ReadDataHi,
  output logic [DATA_WIDTH-1:0] ReadDataLo,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Stall
);

  localparam int PW = 2 * DATA_WIDTH;

  state_t state;
  state_t nextState;

  logic load;
  logic run;
  logic finish;
  logic lastIter;
  logic moveOk;

  logic                  isDivQ;
  logic                  aNegQ;
  logic                  bNegQ;
  logic                  divZeroQ;
  logic [DATA_WIDTH-1:0] aOrigQ;

  logic                  aNeg;
  logic                  bNeg;
  logic [DATA_WIDTH-1:0] magA;
  logic [DATA_WIDTH-1:0] magB;

  logic [DATA_WIDTH-1:0] hiRes;
  logic [DATA_WIDTH-1:0] loRes;
  logic [PW-1:0]         prodMag;
  logic [PW-1:0]         prodFix;
  logic [DATA_WIDTH-1:0] quotFix;
  logic [DATA_WIDTH-1:0] remFix;
  logic [DATA_WIDTH-1:0] hiNext;
  logic [DATA_WIDTH-1:0] loNext;

  logic [DATA_WIDTH-1:0] hiReg;
  logic [DATA_WIDTH-1:0] loReg;

  // Operand magnitudes for the unsigned iterator.
  always_comb begin
    aNeg = isSignedOp(Op) & A[DATA_WIDTH-1];
    bNeg = isSignedOp(Op) & B[DATA_WIDTH-1];
    magA = aNeg ? -A : A;
    magB = bNeg ? -B : B;
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= nextState;
  end

  // Next state and iteration controls.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    run       = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          load      = 1'b1;
          nextState = S_RUN;
        end
      end
      S_RUN: begin
        run = 1'b1;
        if (lastIter) nextState = S_FINISH;
      end
      S_FINISH: begin
        finish    = 1'b1;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Capture op kind and sign info at launch.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      isDivQ   <= 1'b0;
      aNegQ    <= 1'b0;
      bNegQ    <= 1'b0;
      divZeroQ <= 1'b0;
      aOrigQ   <= '0;
    end else if (load) begin
      isDivQ   <= isDivOp(Op);
      aNegQ    <= aNeg;
      bNegQ    <= bNeg;
      divZeroQ <= isDivOp(Op) && (B == '0);
      aOrigQ   <= A;
    end
  end

  mul_div_iterator #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uIter (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (load),
    .run      (run),
    .isDiv    (isDivQ),
    .opA      (magA),
    .opB      (magB),
    .hiRes    (hiRes),
    .loRes    (loRes),
    .lastIter (lastIter)
  );

  // Sign fix-up and HI/LO placement of the result.
  always_comb begin
    prodMag = {hiRes, loRes};
    prodFix = (aNegQ ^ bNegQ) ? -prodMag : prodMag;
    quotFix = (aNegQ ^ bNegQ) ? -loRes : loRes;
    remFix  = aNegQ ? -hiRes : hiRes;
    hiNext  = prodFix[PW-1:DATA_WIDTH];
    loNext  = prodFix[DATA_WIDTH-1:0];
    unique case (1'b1)
      divZeroQ: begin
        hiNext = aOrigQ;
        loNext = DIV_ZERO_QUOT[DATA_WIDTH-1:0];
      end
      (isDivQ && !divZeroQ): begin
        hiNext = remFix;
        loNext = quotFix;
      end
      default: ;
    endcase
  end

  // Moves only land in IDLE and lose to Start.
  assign moveOk = (state == S_IDLE) && !Start;

  // Architectural HI/LO registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (finish) begin
      hiReg <= hiNext;
      loReg <= loNext;
    end else if (moveOk) begin
      if (HiWrite) hiReg <= MoveData;
      if (LoWrite) loReg <= MoveData;
    end
  end

  // One-cycle commit pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) Done <= 1'b0;
    else      Done <= finish;
  end

  assign Busy       = (state != S_IDLE);
  assign Stall      = Busy & (HiLoRead | Start | HiWrite | LoWrite);
  assign ReadDataHi = hiReg;
  assign ReadDataLo = loReg;

endmodule

// File: tb/tb_hi_lo_mul_div.sv
// Directed bench for hi_lo_mul_div.
// Hand-computed vectors, latency and stall.
module tb_hi_lo_mul_div;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        HiWrite;
  logic        LoWrite;
  logic [31:0] MoveData;
  logic        HiLoRead;
  logic [31:0] ReadDataHi;
  logic [31:0] ReadDataLo;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int errors = 0;
  int checks = 0;

  hi_lo_mul_div #(.DATA_WIDTH(32)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Op         (Op),
    .A          (A),
    .B          (B),
    .HiWrite    (HiWrite),
    .LoWrite    (LoWrite),
    .MoveData   (MoveData),
    .HiLoRead   (HiLoRead),
    .ReadDataHi (ReadDataHi),
    .ReadDataLo (ReadDataLo),
    .Busy       (Busy),
    .Done       (Done),
    .Stall      (Stall)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Launch in the current cycle; returns in the Done cycle.
  task automatic runOp(input string tag,
                       input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int early;
    int idle;
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({tag, ".busy1"}, 64'(Busy), 64'd1);
    chk({tag, ".done1"}, 64'(Done), 64'd0);
    early = 0;
    idle  = 0;
    for (int c = 2; c <= 33; c++) begin
      tick();
      if (Done) early++;
      if (!Busy) idle++;
    end
    chk({tag, ".earlyDone"}, 64'(early), 64'd0);
    chk({tag, ".busyGap"}, 64'(idle), 64'd0);
    tick();
    chk({tag, ".done"}, 64'(Done), 64'd1);
    chk({tag, ".busyEnd"}, 64'(Busy), 64'd0);
    chk({tag, ".hi"}, 64'(ReadDataHi), 64'(expHi));
    chk({tag, ".lo"}, 64'(ReadDataLo), 64'(expLo));
  endtask

  initial begin
    int miss;
    int seen;
    Rst = 1'b0; Start = 1'b0; Op = 2'b00;
    A = '0; B = '0; HiWrite = 1'b0; LoWrite = 1'b0;
    MoveData = '0; HiLoRead = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.hi", 64'(ReadDataHi), 64'd0);
    chk("rst.lo", 64'(ReadDataLo), 64'd0);
    chk("rst.busy", 64'(Busy), 64'd0);
    chk("rst.done", 64'(Done), 64'd0);
    chk("rst.stall", 64'(Stall), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    tick();

    runOp("mult", 2'b00, 32'hFFFFFFFD, 32'd7,
          32'hFFFFFFFF, 32'hFFFFFFEB);
    tick();
    chk("mult.donePulse", 64'(Done), 64'd0);
    runOp("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001);
    runOp("div", 2'b10, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divuZero", 2'b11, 32'd10, 32'd0,
          32'h0000000A, 32'hFFFFFFFF);

    // Stall while HI/LO is read during an operation
    tick();
    Op = 2'b00; A = 32'd5; B = 32'd6; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    miss = 0;
    for (int c = 3; c <= 33; c++) begin
      tick();
      HiLoRead = 1'b1;
      if (c == 5) begin
        HiWrite  = 1'b1;
        MoveData = 32'h1234;
      end
      if (c == 6) HiWrite = 1'b0;
      #1;
      if (!Stall) miss++;
      if (c == 7) chk("mthi.ignored", 64'(ReadDataHi), 64'h0000000A);
    end
    chk("stall.held", 64'(miss), 64'd0);
    tick();
    chk("stall.doneCyc", 64'(Stall), 64'd0);
    chk("stall.done", 64'(Done), 64'd1);
    chk("stall.lo", 64'(ReadDataLo), 64'd30);
    chk("stall.hi", 64'(ReadDataHi), 64'd0);
    HiLoRead = 1'b0;

    runOp("ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000);
    runOp("divZero", 2'b10, 32'hFFFFFFFB, 32'd0,
          32'hFFFFFFFB, 32'hFFFFFFFF);
    runOp("divNegB", 2'b10, 32'd7, 32'hFFFFFFFE,
          32'h00000001, 32'hFFFFFFFD);

    // MTLO in IDLE
    tick();
    LoWrite = 1'b1; MoveData = 32'hDEADBEEF;
    #1;
    chk("mtlo.stall", 64'(Stall), 64'd0);
    tick();
    LoWrite = 1'b0;
    chk("mtlo.lo", 64'(ReadDataLo), 64'hDEADBEEF);
    chk("mtlo.hi", 64'(ReadDataHi), 64'h00000001);

    // Reset mid-operation
    Op = 2'b10; A = 32'd100; B = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Rst = 1'b0;
    #1;
    chk("abort.busy", 64'(Busy), 64'd0);
    chk("abort.hi", 64'(ReadDataHi), 64'd0);
    chk("abort.lo", 64'(ReadDataLo), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (Done || Busy) seen++;
    end
    chk("abort.quiet", 64'(seen), 64'd0);
    runOp("post", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
